// File: rtl/rc6_arbiter_if.sv
// ---------------------------------------------------------------------------
// rc6_arbiter_if
// Bundle of every signal between the two-requester RC6 arbiter, its two
// requesters and the shared RC6 engine.
//
//   Requester side : req0/1, zset0/1, datain0/1  (towards the arbiter)
//                    done0/1, dataout0/1, err0/1 (back to the requesters)
//   Engine side    : eng_start, eng_zset, eng_datain (towards the engine)
//                    eng_done, eng_dataout           (back from the engine)
//   Status         : gnt (one-hot engine owner), ops_count (completed ops)
//
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (requesters plus engine)
// ---------------------------------------------------------------------------
interface rc6_arbiter_if;

    logic         req0;
    logic         req1;
    logic         zset0;
    logic         zset1;
    logic [127:0] datain0;
    logic [127:0] datain1;

    logic         done0;
    logic         done1;
    logic [127:0] dataout0;
    logic [127:0] dataout1;
    logic         err0;
    logic         err1;

    logic [1:0]   gnt;
    logic         eng_start;
    logic         eng_zset;
    logic [127:0] eng_datain;
    logic         eng_done;
    logic [127:0] eng_dataout;
    logic [15:0]  ops_count;

    modport slave (
        input  req0, req1, zset0, zset1, datain0, datain1,
        input  eng_done, eng_dataout,
        output done0, done1, dataout0, dataout1, err0, err1,
        output gnt, eng_start, eng_zset, eng_datain, ops_count
    );

    modport master (
        output req0, req1, zset0, zset1, datain0, datain1,
        output eng_done, eng_dataout,
        input  done0, done1, dataout0, dataout1, err0, err1,
        input  gnt, eng_start, eng_zset, eng_datain, ops_count
    );

endinterface

// File: rtl/rc6_arbiter.sv
// ---------------------------------------------------------------------------
// rc6_arbiter
// Shares one RC6 engine between two requesters. Round-robin arbitration on a
// 1-bit last-served pointer, one operation in flight at a time, one-cycle
// done pulse per completed operation and a 16-bit wrapping operation count.
//
// Ports:
//   clk   - single clock, rising edge
//   reset - asynchronous, active-high
//   bus   - rc6_arbiter_if.slave: requester handshakes, engine handshake,
//           gnt and ops_count (see rc6_arbiter_if.sv)
//
// Parameter:
//   TIMEOUT - engine-response watchdog limit in cycles (default 64)
//
// Optional feature macro: RC6_ARB_TIMEOUT_EN
//   defined   - a watchdog counts BUSY cycles; after TIMEOUT cycles without
//               eng_done the operation completes with dataout 0 and err set
//   undefined - no watchdog, BUSY waits for eng_done forever, err0/err1 = 0
//
// Latency: a request seen in IDLE at cycle N gives eng_start at N+1; done_k
// follows eng_done by one cycle. At least one IDLE cycle separates two
// operations because RESP never re-arbitrates.
// ---------------------------------------------------------------------------
module rc6_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset,
    rc6_arbiter_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        LAUNCH = 4'b0010,
        BUSY   = 4'b0100,
        RESP   = 4'b1000
    } state_t;

    // A watchdog of zero cycles is meaningless; refuse to elaborate it.
    if (TIMEOUT < 1) begin : g_timeout_range
        $error("rc6_arbiter: TIMEOUT must be at least 1");
    end

    // Round-robin pick: 1 selects requester 1. ptr is the last-served
    // requester, so on a tie the other one wins.
    function automatic logic arb_pick1(input logic r0, input logic r1, input logic ptr);
        arb_pick1 = r1 & (~r0 | ~ptr);
    endfunction

    state_t       state_r;
    state_t       state_nxt_s;

    logic [1:0]   gnt_r;
    logic [1:0]   gnt_nxt_s;
    logic         ptr_r;
    logic         ptr_nxt_s;
    logic         eng_start_r;
    logic         eng_start_nxt_s;
    logic         eng_zset_r;
    logic         eng_zset_nxt_s;
    logic [127:0] eng_datain_r;
    logic [127:0] eng_datain_nxt_s;
    logic         done0_r;
    logic         done0_nxt_s;
    logic         done1_r;
    logic         done1_nxt_s;
    logic [127:0] dataout0_r;
    logic [127:0] dataout0_nxt_s;
    logic [127:0] dataout1_r;
    logic [127:0] dataout1_nxt_s;
    logic [15:0]  ops_count_r;
    logic [15:0]  ops_count_nxt_s;

`ifdef RC6_ARB_TIMEOUT_EN
    localparam int               TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    logic [TMO_W-1:0] tmo_cnt_r;
    logic [TMO_W-1:0] tmo_cnt_nxt_s;
    logic             err0_r;
    logic             err0_nxt_s;
    logic             err1_r;
    logic             err1_nxt_s;
`endif

    // Next-state and next-output logic for the IDLE/LAUNCH/BUSY/RESP sequencer.
    always_comb begin
        state_nxt_s      = state_r;
        gnt_nxt_s        = gnt_r;
        ptr_nxt_s        = ptr_r;
        eng_start_nxt_s  = 1'b0;
        eng_zset_nxt_s   = eng_zset_r;
        eng_datain_nxt_s = eng_datain_r;
        done0_nxt_s      = 1'b0;
        done1_nxt_s      = 1'b0;
        dataout0_nxt_s   = dataout0_r;
        dataout1_nxt_s   = dataout1_r;
        ops_count_nxt_s  = ops_count_r;
`ifdef RC6_ARB_TIMEOUT_EN
        tmo_cnt_nxt_s    = tmo_cnt_r;
        err0_nxt_s       = 1'b0;
        err1_nxt_s       = 1'b0;
`endif

        case (state_r)
            IDLE: begin
                gnt_nxt_s = 2'b00;
                // Requester inputs are only ever sampled here; the engine
                // registers then hold them for the whole operation.
                if (bus.req0 || bus.req1) begin
                    if (arb_pick1(bus.req0, bus.req1, ptr_r)) begin
                        gnt_nxt_s        = 2'b10;
                        eng_zset_nxt_s   = bus.zset1;
                        eng_datain_nxt_s = bus.datain1;
                    end else begin
                        gnt_nxt_s        = 2'b01;
                        eng_zset_nxt_s   = bus.zset0;
                        eng_datain_nxt_s = bus.datain0;
                    end
                    eng_start_nxt_s = 1'b1;
                    state_nxt_s     = LAUNCH;
                end else begin
                    state_nxt_s = IDLE;
                end
            end

            LAUNCH: begin
`ifdef RC6_ARB_TIMEOUT_EN
                tmo_cnt_nxt_s = {TMO_W{1'b0}};
`endif
                state_nxt_s = BUSY;
            end

            BUSY: begin
                if (bus.eng_done) begin
                    if (gnt_r[1]) begin
                        dataout1_nxt_s = bus.eng_dataout;
                    end else begin
                        dataout0_nxt_s = bus.eng_dataout;
                    end
                    done0_nxt_s     = gnt_r[0];
                    done1_nxt_s     = gnt_r[1];
                    ops_count_nxt_s = ops_count_r + 16'd1;
                    state_nxt_s     = RESP;
                end
`ifdef RC6_ARB_TIMEOUT_EN
                // Watchdog expiry: finish the operation with a zero result
                // and the error flag so the requester is never stranded.
                else if (tmo_cnt_r == TMO_LAST) begin
                    if (gnt_r[1]) begin
                        dataout1_nxt_s = 128'd0;
                    end else begin
                        dataout0_nxt_s = 128'd0;
                    end
                    done0_nxt_s     = gnt_r[0];
                    done1_nxt_s     = gnt_r[1];
                    err0_nxt_s      = gnt_r[0];
                    err1_nxt_s      = gnt_r[1];
                    ops_count_nxt_s = ops_count_r + 16'd1;
                    state_nxt_s     = RESP;
                end else begin
                    tmo_cnt_nxt_s = tmo_cnt_r + TMO_ONE;
                    state_nxt_s   = BUSY;
                end
`else
                else begin
                    state_nxt_s = BUSY;
                end
`endif
            end

            RESP: begin
                // done_k is visible this cycle; hand the engine back and
                // remember who was just served.
                ptr_nxt_s   = gnt_r[1];
                gnt_nxt_s   = 2'b00;
                state_nxt_s = IDLE;
            end

            default: begin
                // Not a legal one-hot code: drop the engine and recover.
                gnt_nxt_s   = 2'b00;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and output registers; every output comes straight from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_r        <= 2'b00;
            ptr_r        <= 1'b1;
            eng_start_r  <= 1'b0;
            eng_zset_r   <= 1'b0;
            eng_datain_r <= 128'd0;
            done0_r      <= 1'b0;
            done1_r      <= 1'b0;
            dataout0_r   <= 128'd0;
            dataout1_r   <= 128'd0;
            ops_count_r  <= 16'd0;
        end else begin
            gnt_r        <= gnt_nxt_s;
            ptr_r        <= ptr_nxt_s;
            eng_start_r  <= eng_start_nxt_s;
            eng_zset_r   <= eng_zset_nxt_s;
            eng_datain_r <= eng_datain_nxt_s;
            done0_r      <= done0_nxt_s;
            done1_r      <= done1_nxt_s;
            dataout0_r   <= dataout0_nxt_s;
            dataout1_r   <= dataout1_nxt_s;
            ops_count_r  <= ops_count_nxt_s;
        end
    end

`ifdef RC6_ARB_TIMEOUT_EN
    // Watchdog counter and error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
            err0_r    <= 1'b0;
            err1_r    <= 1'b0;
        end else begin
            tmo_cnt_r <= tmo_cnt_nxt_s;
            err0_r    <= err0_nxt_s;
            err1_r    <= err1_nxt_s;
        end
    end

    assign bus.err0 = err0_r;
    assign bus.err1 = err1_r;
`else
    assign bus.err0 = 1'b0;
    assign bus.err1 = 1'b0;
`endif

    assign bus.gnt        = gnt_r;
    assign bus.eng_start  = eng_start_r;
    assign bus.eng_zset   = eng_zset_r;
    assign bus.eng_datain = eng_datain_r;
    assign bus.done0      = done0_r;
    assign bus.done1      = done1_r;
    assign bus.dataout0   = dataout0_r;
    assign bus.dataout1   = dataout1_r;
    assign bus.ops_count  = ops_count_r;

endmodule

// File: tb/tb_rc6_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rc6_arbiter
// Directed self-checking bench for rc6_arbiter with a stub RC6 engine.
// Stub modes: 0 = returns 0xA5 repeated, 1 = returns ~eng_datain,
// 2 = never responds. Stub latency in cycles from the eng_start cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rc6_arbiter;

    localparam logic [127:0] A5 = {16{8'hA5}};
    localparam logic [127:0] D0 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] DA = 128'hDEADBEEF00000001CAFEF00D12345678;
    localparam logic [127:0] DB = 128'h0F0F0F0F1234567889ABCDEF55AA55AA;
    localparam logic [127:0] DC = 128'h3333444455556666777788889999AAAA;
    localparam logic [127:0] DD = 128'hFFFF0000FFFF0000FFFF0000FFFF0000;
    localparam logic [127:0] DE = 128'h0000000100000002000000030000000F;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   stub_lat  = 44;
    int   stub_mode = 0;

    always #5 clk = ~clk;

    rc6_arbiter_if bus ();

    rc6_arbiter #(.TIMEOUT(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Stub engine: answers each eng_start after stub_lat cycles.
    initial begin
        logic [127:0] res;
        bus.eng_done    = 1'b0;
        bus.eng_dataout = 128'd0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.eng_start === 1'b1 && stub_mode != 2) begin
                if (stub_mode == 1) res = ~bus.eng_datain;
                else                res = A5;
                repeat (stub_lat) @(posedge clk);
                #1;
                bus.eng_done    = 1'b1;
                bus.eng_dataout = res;
                @(posedge clk);
                #1;
                bus.eng_done    = 1'b0;
                bus.eng_dataout = 128'd0;
            end
        end
    end

    // Bounded wait: 0 = eng_start, 1 = done0, 2 = done1, 3 = either done.
    task automatic wait_sig(input int which, input int max_cyc, output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < max_cyc) begin
            @(posedge clk);
            #1;
            cyc++;
            case (which)
                0:       seen = (bus.eng_start === 1'b1);
                1:       seen = (bus.done0 === 1'b1);
                2:       seen = (bus.done1 === 1'b1);
                default: seen = (bus.done0 === 1'b1) || (bus.done1 === 1'b1);
            endcase
        end
    endtask

    task automatic test_reset();
        logic [2+6+128*3+16-1:0] v;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        v = {bus.gnt, bus.done0, bus.done1, bus.err0, bus.err1, bus.eng_start, bus.eng_zset,
             bus.eng_datain, bus.dataout0, bus.dataout1, bus.ops_count};
        n_checks++;
        if (v !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected all zero", v);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.gnt !== 2'b00 || bus.eng_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got gnt=%b eng_start=%b expected 00/0", bus.gnt, bus.eng_start);
        end
    endtask

    task automatic test_single();
        int c;
        bit seen;
        stub_mode   = 0;
        stub_lat    = 44;
        bus.req0    = 1'b1;
        bus.zset0   = 1'b1;
        bus.datain0 = D0;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.eng_start !== 1'b1 || bus.eng_zset !== 1'b1 || bus.gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL single_launch: got start=%b zset=%b gnt=%b expected 1/1/01",
                     bus.eng_start, bus.eng_zset, bus.gnt);
        end
        n_checks++;
        if (bus.eng_datain !== D0) begin
            n_fail++;
            $display("FAIL single_datain: got %h expected %h", bus.eng_datain, D0);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.eng_start !== 1'b0 || bus.eng_zset !== 1'b1) begin
            n_fail++;
            $display("FAIL single_start_pulse: got start=%b zset=%b expected 0/1", bus.eng_start, bus.eng_zset);
        end
        wait_sig(1, 100, c, seen);
        bus.req0 = 1'b0;
        n_checks++;
        if (!seen || c != 44) begin
            n_fail++;
            $display("FAIL single_latency: got done0 seen=%0d at %0d cycles after eng_start expected 45",
                     seen, c + 1);
        end
        n_checks++;
        if (bus.dataout0 !== A5 || bus.ops_count !== 16'd1 || bus.err0 !== 1'b0 || bus.done1 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_result: got dout=%h ops=%h err0=%b done1=%b expected %h/0001/0/0",
                     bus.dataout0, bus.ops_count, bus.err0, bus.done1, A5);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.done0 !== 1'b0 || bus.gnt !== 2'b00 || bus.dataout0 !== A5) begin
            n_fail++;
            $display("FAIL single_after: got done0=%b gnt=%b dout=%h expected 0/00/held",
                     bus.done0, bus.gnt, bus.dataout0);
        end
    endtask

    task automatic test_tie();
        int c;
        bit seen;
        bit exp1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset       = 1'b0;
        stub_mode   = 1;
        stub_lat    = 5;
        bus.datain0 = DA;
        bus.datain1 = DB;
        bus.zset0   = 1'b1;
        bus.zset1   = 1'b0;
        bus.req0    = 1'b1;
        bus.req1    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp1 = (k % 2 == 1);
            wait_sig(0, 20, c, seen);
            n_checks++;
            if (!seen || bus.gnt !== (exp1 ? 2'b10 : 2'b01) || bus.eng_zset !== ~exp1) begin
                n_fail++;
                $display("FAIL tie_gnt[%0d]: got seen=%0d gnt=%b zset=%b expected gnt=%b zset=%b",
                         k, seen, bus.gnt, bus.eng_zset, exp1 ? 2'b10 : 2'b01, ~exp1);
            end
            wait_sig(3, 20, c, seen);
            if (k == 3) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
            n_checks++;
            if (!seen || bus.done0 !== ~exp1 || bus.done1 !== exp1) begin
                n_fail++;
                $display("FAIL tie_done[%0d]: got seen=%0d done0=%b done1=%b expected done%0d only",
                         k, seen, bus.done0, bus.done1, exp1);
            end
            n_checks++;
            if (exp1 ? (bus.dataout1 !== ~DB) : (bus.dataout0 !== ~DA)) begin
                n_fail++;
                $display("FAIL tie_data[%0d]: got dout0=%h dout1=%h", k, bus.dataout0, bus.dataout1);
            end
        end
        n_checks++;
        if (bus.dataout0 !== ~DA || bus.ops_count !== 16'd4) begin
            n_fail++;
            $display("FAIL tie_hold: got dout0=%h ops=%h expected %h/0004", bus.dataout0, bus.ops_count, ~DA);
        end
    endtask

    task automatic test_withdrawal();
        int c;
        bit seen;
        stub_mode   = 1;
        stub_lat    = 10;
        bus.req1    = 1'b1;
        bus.zset1   = 1'b0;
        bus.datain1 = DC;
        wait_sig(0, 20, c, seen);
        n_checks++;
        if (!seen || bus.gnt !== 2'b10 || bus.eng_zset !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_grant: got seen=%0d gnt=%b zset=%b expected 10/0", seen, bus.gnt, bus.eng_zset);
        end
        repeat (3) @(posedge clk);
        #1;
        bus.req1    = 1'b0;
        bus.datain1 = DD;
        bus.zset1   = 1'b1;
        bus.req0    = 1'b1;
        bus.zset0   = 1'b0;
        bus.datain0 = DE;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.eng_datain !== DC || bus.eng_zset !== 1'b0 || bus.gnt !== 2'b10) begin
            n_fail++;
            $display("FAIL wd_hold: got din=%h zset=%b gnt=%b expected %h/0/10",
                     bus.eng_datain, bus.eng_zset, bus.gnt, DC);
        end
        wait_sig(2, 30, c, seen);
        n_checks++;
        if (!seen || bus.dataout1 !== ~DC) begin
            n_fail++;
            $display("FAIL wd_done1: got seen=%0d dout1=%h expected %h", seen, bus.dataout1, ~DC);
        end
        wait_sig(0, 20, c, seen);
        n_checks++;
        if (!seen || bus.gnt !== 2'b01 || bus.eng_datain !== DE) begin
            n_fail++;
            $display("FAIL wd_next: got seen=%0d gnt=%b din=%h expected 01/%h", seen, bus.gnt, bus.eng_datain, DE);
        end
        wait_sig(1, 30, c, seen);
        bus.req0 = 1'b0;
        n_checks++;
        if (!seen || bus.dataout0 !== ~DE || bus.ops_count !== 16'd6) begin
            n_fail++;
            $display("FAIL wd_done0: got seen=%0d dout0=%h ops=%h expected %h/0006",
                     seen, bus.dataout0, bus.ops_count, ~DE);
        end
    endtask

    task automatic test_timeout();
        int c;
        bit seen;
`ifdef RC6_ARB_TIMEOUT_EN
        stub_mode = 2;
`else
        stub_mode = 0;
        stub_lat  = 150;
`endif
        bus.req0    = 1'b1;
        bus.zset0   = 1'b1;
        bus.datain0 = DA;
        wait_sig(0, 20, c, seen);
        n_checks++;
        if (!seen || bus.gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL tmo_grant: got seen=%0d gnt=%b expected 01", seen, bus.gnt);
        end
        wait_sig(3, 200, c, seen);
        bus.req0 = 1'b0;
`ifdef RC6_ARB_TIMEOUT_EN
        n_checks++;
        if (!seen || c != 65 || bus.done0 !== 1'b1 || bus.err0 !== 1'b1 || bus.dataout0 !== 128'd0) begin
            n_fail++;
            $display("FAIL tmo_expire: got seen=%0d cycles=%0d done0=%b err0=%b dout0=%h expected 65/1/1/0",
                     seen, c, bus.done0, bus.err0, bus.dataout0);
        end
`else
        n_checks++;
        if (!seen || c != 151 || bus.done0 !== 1'b1 || bus.err0 !== 1'b0 || bus.dataout0 !== A5) begin
            n_fail++;
            $display("FAIL tmo_wait: got seen=%0d cycles=%0d done0=%b err0=%b dout0=%h expected 151/1/0/%h",
                     seen, c, bus.done0, bus.err0, bus.dataout0, A5);
        end
`endif
        n_checks++;
        if (bus.ops_count !== 16'd7) begin
            n_fail++;
            $display("FAIL tmo_ops: got %h expected 0007", bus.ops_count);
        end
        stub_mode   = 0;
        stub_lat    = 3;
        bus.req1    = 1'b1;
        bus.datain1 = DB;
        wait_sig(0, 20, c, seen);
        n_checks++;
        if (!seen || bus.gnt !== 2'b10) begin
            n_fail++;
            $display("FAIL tmo_next_grant: got seen=%0d gnt=%b expected 10", seen, bus.gnt);
        end
        wait_sig(3, 20, c, seen);
        bus.req1 = 1'b0;
        n_checks++;
        if (!seen || c != 4 || bus.done1 !== 1'b1 || bus.err1 !== 1'b0 || bus.dataout1 !== A5) begin
            n_fail++;
            $display("FAIL tmo_next_done: got seen=%0d cycles=%0d done1=%b err1=%b dout1=%h expected 4/1/0/%h",
                     seen, c, bus.done1, bus.err1, bus.dataout1, A5);
        end
    endtask

    task automatic test_reset_busy();
        int c;
        bit seen;
        int dones;
        int starts;
        int busy;
        logic [2+6+128*3+16-1:0] v;
        stub_mode   = 0;
        stub_lat    = 20;
        bus.req0    = 1'b1;
        bus.zset0   = 1'b1;
        bus.datain0 = DC;
        wait_sig(0, 20, c, seen);
        n_checks++;
        if (!seen || bus.eng_zset !== 1'b1) begin
            n_fail++;
            $display("FAIL rb_launch: got seen=%0d zset=%b expected 1", seen, bus.eng_zset);
        end
        repeat (10) @(posedge clk);
        #1;
        reset    = 1'b1;
        bus.req0 = 1'b0;
        #1;
        n_checks++;
        if (bus.gnt !== 2'b00 || bus.eng_zset !== 1'b0 || bus.ops_count !== 16'd0) begin
            n_fail++;
            $display("FAIL rb_async: got gnt=%b zset=%b ops=%h expected 00/0/0000",
                     bus.gnt, bus.eng_zset, bus.ops_count);
        end
        @(posedge clk);
        #1;
        reset  = 1'b0;
        dones  = 0;
        starts = 0;
        busy   = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (bus.done0 === 1'b1 || bus.done1 === 1'b1) dones++;
            if (bus.eng_start !== 1'b0) starts++;
            if (bus.gnt !== 2'b00) busy++;
        end
        n_checks++;
        if (dones != 0 || starts != 0 || busy != 0) begin
            n_fail++;
            $display("FAIL rb_quiet: got dones=%0d starts=%0d busy=%0d expected 0/0/0", dones, starts, busy);
        end
        v = {bus.gnt, bus.done0, bus.done1, bus.err0, bus.err1, bus.eng_start, bus.eng_zset,
             bus.eng_datain, bus.dataout0, bus.dataout1, bus.ops_count};
        n_checks++;
        if (v !== '0) begin
            n_fail++;
            $display("FAIL rb_outputs: got %h expected all zero", v);
        end
    endtask

    task automatic test_wrap();
        int c;
        bit seen;
        #1;
        force dut.ops_count_r = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.ops_count_r;
        #1;
        n_checks++;
        if (bus.ops_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap_preload: got %h expected ffff", bus.ops_count);
        end
        stub_mode   = 1;
        stub_lat    = 4;
        bus.req1    = 1'b1;
        bus.zset1   = 1'b0;
        bus.datain1 = DE;
        wait_sig(2, 30, c, seen);
        bus.req1 = 1'b0;
        n_checks++;
        if (!seen || bus.ops_count !== 16'h0000 || bus.dataout1 !== ~DE) begin
            n_fail++;
            $display("FAIL wrap_count: got seen=%0d ops=%h dout1=%h expected 0000/%h",
                     seen, bus.ops_count, bus.dataout1, ~DE);
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus.req0    = 1'b0;
        bus.req1    = 1'b0;
        bus.zset0   = 1'b0;
        bus.zset1   = 1'b0;
        bus.datain0 = 128'd0;
        bus.datain1 = 128'd0;
        test_reset();
        test_single();
        test_tie();
        test_withdrawal();
        test_timeout();
        test_reset_busy();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rc6_arbiter.md
RC6_ARBITER -- requirements
Module: rc6_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: engine-response watchdog limit in clock cycles, only used when RC6_ARB_TIMEOUT_EN is defined.
REQ-002 Port clk, input, 1: single clock; all logic on rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Ports req0 and req1, input, 1 each: requester k requests one RC6 operation; held high until done_k.
REQ-005 Ports zset0 and zset1, input, 1 each: requester k mode, 1 = encrypt, 0 = decrypt.
REQ-006 Ports datain0 and datain1, input, 128 each: requester k block, stable while req_k is high.
REQ-007 Ports done0 and done1, output, 1 each: one-cycle completion pulse to requester k.
REQ-008 Ports dataout0 and dataout1, output, 128 each: result for requester k, valid in the done_k cycle and held until the next done_k.
REQ-009 Ports err0 and err1, output, 1 each: timeout flag, valid with done_k.
REQ-010 Port gnt, output, 2: one-hot owner of the engine; 00 when idle.
REQ-011 Port eng_start, output, 1: one-cycle start pulse to the RC6 engine.
REQ-012 Port eng_zset, output, 1: mode to the engine, held from eng_start until completion.
REQ-013 Port eng_datain, output, 128: block to the engine, held from eng_start until completion.
REQ-014 Port eng_done, input, 1: engine completion pulse.
REQ-015 Port eng_dataout, input, 128: engine result, valid when eng_done=1.
REQ-016 Port ops_count, output, 16: count of completed operations.

Function
REQ-017 The FSM SHALL have four states: IDLE, LAUNCH, BUSY and RESP; the state register SHALL be one-hot.
REQ-018 In IDLE, with any req_k high, the FSM SHALL select a winner, latch its zset/datain into the engine registers, set gnt, and go to LAUNCH next cycle.
REQ-019 Arbitration SHALL be round-robin on a 1-bit last-served pointer: with both requesting, the requester not last served wins; with one requesting, it wins.
REQ-020 In LAUNCH, eng_start SHALL be 1 for exactly that cycle, and the FSM SHALL go to BUSY.
REQ-021 In BUSY, on eng_done=1 the block SHALL capture eng_dataout into dataout of the granted requester and go to RESP.
REQ-022 In RESP, done_k of the granted requester SHALL be 1 for one cycle, the pointer SHALL update, ops_count SHALL increment, and the FSM SHALL return to IDLE with gnt=00.
REQ-023 Latency: req seen in IDLE at cycle N gives eng_start at N+1, and done_k one cycle after eng_done.
REQ-024 req/zset/datain SHALL be sampled only in IDLE; changes or withdrawal during LAUNCH..RESP SHALL be ignored, and the operation SHALL complete and pulse done_k.
REQ-025 eng_done outside BUSY SHALL be ignored.
REQ-026 The block SHALL NOT re-arbitrate in the RESP cycle, so there is a minimum of one IDLE cycle between operations.
REQ-027 ops_count SHALL wrap from FFFF to 0000 without any flag.

Reset
REQ-028 Reset SHALL force IDLE and set the pointer to 1, so requester 0 wins the first tie.
REQ-029 Reset SHALL clear gnt, done0/1, err0/1, eng_start, eng_zset, eng_datain, dataout0/1 and ops_count to 0.
REQ-030 Reset mid-operation SHALL abandon the operation with no done pulse; an eng_done arriving after reset SHALL be ignored.

Configuration
REQ-031 Macro RC6_ARB_TIMEOUT_EN defined: a cycle counter SHALL run in BUSY.
- On reaching TIMEOUT without eng_done, the FSM SHALL go to RESP.
- dataout_k SHALL be 0, and err_k SHALL be 1 with done_k.
- ops_count SHALL still increment.
REQ-032 Macro RC6_ARB_TIMEOUT_EN undefined: no counter is built, BUSY waits indefinitely, and err0/err1 SHALL be tied to 0.

Verification
REQ-033 Single request: req0=1, zset0=1, datain0=0x0123..EF; stub engine with 44-cycle latency returns 0xA5 repeated.
- Required: eng_start 1 cycle after req, eng_zset=1.
- Required: done0 45 cycles after eng_start, dataout0=0xA5..A5, ops_count=1.
REQ-034 Tie after reset: req0 and req1 both high.
- Required: gnt sequence 01, 10, 01, ...
- Required: done0 and done1 alternate, and each dataout carries its own stub result.
REQ-035 Withdrawal: req1 drops 3 cycles after eng_start.
- Required: done1 still pulses, and the next grant goes to req0 if requesting.
REQ-036 Reset mid-BUSY: assert reset 10 cycles after eng_start, then stub eng_done.
- Required: all outputs 0, no done pulse, FSM stays IDLE.
REQ-037 With RC6_ARB_TIMEOUT_EN and TIMEOUT=64, stub engine never responds.
- Required: done0=1 and err0=1 with dataout0=0, 65 cycles after eng_start.
- Required: the block is then idle and serves the next request normally.
REQ-038 Wrap: preload ops_count=FFFF by forcing, then complete one operation.
- Required: ops_count=0000.
